// File: rtl/alu_dmem_datapath.sv
// Execute/memory datapath slice: 32-bit ALU with Z/N flags, PC+4 incrementer,
// and a byte-addressed big-endian data memory with byte/halfword/word access.
// ALU and incrementer are purely combinational; the memory writes on the rising
// clock edge, reads combinationally, and is cleared by an asynchronous reset.
module alu_dmem_datapath #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 9,
  parameter int MEM_DEPTH = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  input  logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_out,
  output logic              alu_z,
  output logic              alu_n,
  input  logic [DATA_W-1:0] pc_in,
  output logic [DATA_W-1:0] pc_plus4,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_di,
  input  logic [1:0]        mem_size,
  input  logic              mem_rw,
  input  logic              mem_en,
  input  logic              mem_se,
  output logic [DATA_W-1:0] mem_do
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_NOR  = 4'b0101,
    OP_SLL  = 4'b0110,
    OP_SRL  = 4'b0111,
    OP_SRA  = 4'b1000,
    OP_SLT  = 4'b1001,
    OP_SLTU = 4'b1010,
    OP_PASA = 4'b1011,
    OP_PASB = 4'b1100,
    OP_RA   = 4'b1101
  } alu_op_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01
  } mem_size_e;

  logic [4:0] shamt;
  assign shamt = alu_a[4:0];

  // ALU result selection; Z and N always follow the final result.
  always_comb begin
    // NOTE: default assignment first so every path drives alu_out and no latch is inferred.
    alu_out = '0;
    case (alu_op)
      OP_ADD:  alu_out = alu_a + alu_b;
      OP_SUB:  alu_out = alu_a - alu_b;
      OP_AND:  alu_out = alu_a & alu_b;
      OP_OR:   alu_out = alu_a | alu_b;
      OP_XOR:  alu_out = alu_a ^ alu_b;
      OP_NOR:  alu_out = ~(alu_a | alu_b);
      OP_SLL:  alu_out = alu_b << shamt;
      OP_SRL:  alu_out = alu_b >> shamt;
      OP_SRA:  alu_out = $signed(alu_b) >>> shamt;
      OP_SLT:  alu_out = {{(DATA_W-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      OP_SLTU: alu_out = {{(DATA_W-1){1'b0}}, (alu_a < alu_b)};
      OP_PASA: alu_out = alu_a;
      OP_PASB: alu_out = alu_b;
      OP_RA:   alu_out = alu_b + DATA_W'(8);
      default: alu_out = '0;
    endcase
  end

  assign alu_z    = (alu_out == '0);
  assign alu_n    = alu_out[DATA_W-1];
  assign pc_plus4 = pc_in + DATA_W'(4);

  // Byte storage; byte at the access address is the most significant byte.
  logic [7:0] mem [MEM_DEPTH];

  // Consecutive byte addresses, wrapping modulo the memory size.
  logic [ADDR_W-1:0] a0, a1, a2, a3;
  assign a0 = mem_addr;
  assign a1 = mem_addr + ADDR_W'(1);
  assign a2 = mem_addr + ADDR_W'(2);
  assign a3 = mem_addr + ADDR_W'(3);

  // Memory write port, with the whole array cleared by asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: this memory is architecturally cleared on reset, so it must be built
      // from flops; a RAM macro without a reset port could not implement it.
      for (int i = 0; i < MEM_DEPTH; i++) begin
        // NOTE: non-blocking assignments for all sequential state, so every flop
        // samples pre-edge values regardless of statement order.
        mem[i] <= '0;
      end
    end else if (mem_en && mem_rw) begin
      case (mem_size)
        SZ_BYTE: begin
          mem[a0] <= mem_di[7:0];
        end
        SZ_HALF: begin
          mem[a0] <= mem_di[15:8];
          mem[a1] <= mem_di[7:0];
        end
        default: begin
          mem[a0] <= mem_di[31:24];
          mem[a1] <= mem_di[23:16];
          mem[a2] <= mem_di[15:8];
          mem[a3] <= mem_di[7:0];
        end
      endcase
    end
  end

  logic [7:0] b0, b1, b2, b3;
  assign b0 = mem[a0];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  // Combinational read with sign/zero extension; zero when idle, writing or in reset.
  always_comb begin
    mem_do = '0;
    if (!reset && mem_en && !mem_rw) begin
      case (mem_size)
        SZ_BYTE: mem_do = {{24{mem_se & b0[7]}}, b0};
        SZ_HALF: mem_do = {{16{mem_se & b0[7]}}, b0, b1};
        default: mem_do = {b0, b1, b2, b3};
      endcase
    end
  end

endmodule

// File: tb/tb_alu_dmem_datapath.sv
// Directed self-checking bench for alu_dmem_datapath: ALU opcodes and flags,
// PC incrementer wrap, big-endian memory accesses with wrap, enable gating and
// asynchronous reset clearing.
module tb_alu_dmem_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_out;
  logic        alu_z, alu_n;
  logic [31:0] pc_in, pc_plus4;
  logic [8:0]  mem_addr;
  logic [31:0] mem_di;
  logic [1:0]  mem_size;
  logic        mem_rw, mem_en, mem_se;
  logic [31:0] mem_do;

  int checks = 0;
  int errors = 0;

  alu_dmem_datapath dut (
    .clk      (clk),
    .reset    (reset),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_out  (alu_out),
    .alu_z    (alu_z),
    .alu_n    (alu_n),
    .pc_in    (pc_in),
    .pc_plus4 (pc_plus4),
    .mem_addr (mem_addr),
    .mem_di   (mem_di),
    .mem_size (mem_size),
    .mem_rw   (mem_rw),
    .mem_en   (mem_en),
    .mem_se   (mem_se),
    .mem_do   (mem_do)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic alu_check(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_out,
                           input logic exp_z, input logic exp_n);
    alu_op = op;
    alu_a  = a;
    alu_b  = b;
    #1;
    check({tag, ".out"}, alu_out, exp_out);
    check({tag, ".z"}, {31'b0, alu_z}, {31'b0, exp_z});
    check({tag, ".n"}, {31'b0, alu_n}, {31'b0, exp_n});
  endtask

  task automatic pc_check(input string tag, input logic [31:0] pc, input logic [31:0] exp);
    pc_in = pc;
    #1;
    check(tag, pc_plus4, exp);
  endtask

  task automatic mem_write(input logic [8:0] addr, input logic [31:0] data, input logic [1:0] size);
    @(negedge clk);
    mem_addr = addr;
    mem_di   = data;
    mem_size = size;
    mem_rw   = 1'b1;
    mem_en   = 1'b1;
    @(negedge clk);
    mem_en   = 1'b0;
    mem_rw   = 1'b0;
  endtask

  task automatic mem_read(input string tag, input logic [8:0] addr, input logic [1:0] size,
                          input logic se, input logic [31:0] exp);
    @(negedge clk);
    mem_addr = addr;
    mem_size = size;
    mem_se   = se;
    mem_rw   = 1'b0;
    mem_en   = 1'b1;
    #1;
    check(tag, mem_do, exp);
    mem_en   = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    alu_a    = '0;
    alu_b    = '0;
    alu_op   = '0;
    pc_in    = '0;
    mem_addr = '0;
    mem_di   = '0;
    mem_size = 2'b10;
    mem_rw   = 1'b0;
    mem_en   = 1'b1;
    mem_se   = 1'b0;

    // Reset state: read port forced to zero while reset is high.
    repeat (2) @(negedge clk);
    #1;
    check("rst_do", mem_do, 32'h0);
    mem_en = 1'b0;
    reset  = 1'b0;
    mem_read("rst_mem0", 9'h000, 2'b10, 1'b0, 32'h0);

    // ALU
    alu_check("add",  4'b0000, 32'd5, 32'd3, 32'd8, 1'b0, 1'b0);
    alu_check("sub",  4'b0001, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b1);
    alu_check("subz", 4'b0001, 32'd7, 32'd7, 32'h0, 1'b1, 1'b0);
    alu_check("and",  4'b0010, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1'b0, 1'b0);
    alu_check("or",   4'b0011, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 1'b0, 1'b1);
    alu_check("xor",  4'b0100, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0, 1'b0, 1'b1);
    alu_check("nor",  4'b0101, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h000F_F000, 1'b0, 1'b0);
    alu_check("sll",  4'b0110, 32'd4, 32'd1, 32'h10, 1'b0, 1'b0);
    alu_check("srl",  4'b0111, 32'd4, 32'h8000_0000, 32'h0800_0000, 1'b0, 1'b0);
    alu_check("sra",  4'b1000, 32'd4, 32'h8000_0000, 32'hF800_0000, 1'b0, 1'b1);
    alu_check("sra5", 4'b1000, 32'h0000_0024, 32'h8000_0000, 32'hF800_0000, 1'b0, 1'b1);
    alu_check("slt",  4'b1001, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
    alu_check("sltu", 4'b1010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
    alu_check("pasa", 4'b1011, 32'h8765_4321, 32'd1, 32'h8765_4321, 1'b0, 1'b1);
    alu_check("pasb", 4'b1100, 32'd1, 32'h1357_9BDF, 32'h1357_9BDF, 1'b0, 1'b0);
    alu_check("ra",   4'b1101, 32'd0, 32'h10, 32'h18, 1'b0, 1'b0);
    alu_check("op14", 4'b1110, 32'd5, 32'd3, 32'h0, 1'b1, 1'b0);
    alu_check("op15", 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);

    // PC incrementer
    pc_check("pc0",    32'h0, 32'h4);
    pc_check("pcwrap", 32'hFFFF_FFFC, 32'h0);
    pc_check("pcmid",  32'h0040_0000, 32'h0040_0004);

    // Word write and mixed-size reads
    mem_write(9'h004, 32'hDEAD_BEEF, 2'b10);
    mem_read("rd_word",   9'h004, 2'b10, 1'b0, 32'hDEAD_BEEF);
    mem_read("rd_sz11",   9'h004, 2'b11, 1'b1, 32'hDEAD_BEEF);
    mem_read("rd_b_se",   9'h004, 2'b00, 1'b1, 32'hFFFF_FFDE);
    mem_read("rd_b_ze",   9'h004, 2'b00, 1'b0, 32'h0000_00DE);
    mem_read("rd_h_se",   9'h006, 2'b01, 1'b1, 32'hFFFF_BEEF);
    mem_read("rd_h_ze",   9'h006, 2'b01, 1'b0, 32'h0000_BEEF);
    mem_read("rd_b7_se",  9'h007, 2'b00, 1'b1, 32'hFFFF_FFEF);

    // Byte and halfword writes, including wrap at the top address
    mem_write(9'h010, 32'hAAAA_AA7F, 2'b00);
    mem_read("byte_word", 9'h010, 2'b10, 1'b0, 32'h7F00_0000);
    mem_read("byte_se",   9'h010, 2'b00, 1'b1, 32'h0000_007F);
    mem_write(9'h1FF, 32'hFFFF_1234, 2'b01);
    mem_read("hwrap_hi",  9'h1FF, 2'b00, 1'b0, 32'h0000_0012);
    mem_read("hwrap_lo",  9'h000, 2'b00, 1'b0, 32'h0000_0034);
    mem_read("hwrap_h",   9'h1FF, 2'b01, 1'b1, 32'h0000_1234);
    mem_write(9'h1FE, 32'hAABB_CCDD, 2'b10);
    mem_read("wwrap",     9'h1FE, 2'b10, 1'b0, 32'hAABB_CCDD);
    mem_read("wwrap_b1",  9'h001, 2'b00, 1'b0, 32'h0000_00DD);

    // Enable and direction gating
    @(negedge clk);
    mem_addr = 9'h004;
    mem_size = 2'b10;
    mem_rw   = 1'b0;
    mem_en   = 1'b0;
    #1;
    check("en0", mem_do, 32'h0);
    mem_rw = 1'b1;
    mem_en = 1'b1;
    mem_di = 32'hDEAD_BEEF;
    #1;
    check("rw1", mem_do, 32'h0);
    mem_en = 1'b0;
    mem_rw = 1'b0;

    // Asynchronous reset mid-cycle clears memory and forces the read port low
    @(negedge clk);
    mem_addr = 9'h004;
    mem_size = 2'b10;
    mem_en   = 1'b1;
    #1;
    check("pre_rst", mem_do, 32'hDEAD_BEEF);
    #2 reset = 1'b1;
    #1;
    check("rst_async", mem_do, 32'h0);

    // A write edge while reset is high is discarded
    mem_addr = 9'h020;
    mem_di   = 32'h1122_3344;
    mem_rw   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_en   = 1'b0;
    mem_rw   = 1'b0;
    reset    = 1'b0;
    mem_read("rst_wr",    9'h020, 2'b10, 1'b0, 32'h0);
    mem_read("rst_w4",    9'h004, 2'b10, 1'b0, 32'h0);
    mem_read("rst_w1fe",  9'h1FE, 2'b10, 1'b0, 32'h0);
    mem_read("rst_b10",   9'h010, 2'b00, 1'b1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
